// File: rtl/adder_pkg.sv
// adder_pkg
// Shared definitions for the serial arithmetic blocks.
// Holds the two-state sequencer encoding used by serial_adder and
// intended for reuse by later bit-serial datapaths.
package adder_pkg;

    // IDLE waits for a start strobe, BUSY processes one bit per clock
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/full_adder.sv
// full_adder
// One-bit combinational full adder cell.
// Ports:
//   a, b       - operand bits
//   carry_in   - incoming carry
//   sum        - a ^ b ^ carry_in
//   carry_out  - majority of the three inputs
module full_adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial WIDTH-bit adder. Operands and carry-in are captured on an
// accepted start, one bit is added per clock (LSB first) through a single
// full_adder cell, and the registered result is presented with a
// one-cycle done pulse.
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   start      - request, only honoured while idle
//   a, b       - WIDTH-bit operands, captured on accepted start
//   carry_in   - initial carry, captured on accepted start
//   busy       - high while an addition is in progress
//   done       - one-cycle pulse when sum/carry_out have just updated
//   sum        - registered result, held until the next completion
//   carry_out  - registered final carry, held until the next completion
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt;
    logic             c_reg;
    logic             fa_sum;
    logic             fa_carry;

    // The single adder cell always sees the current LSBs and the running carry
    full_adder u_full_adder (
        .a         (a_sh[0]),
        .b         (b_sh[0]),
        .carry_in  (c_reg),
        .sum       (fa_sum),
        .carry_out (fa_carry)
    );

    // New sum bits enter at the MSB so that after WIDTH shifts the first
    // (LSB) result bit has reached position 0. A one-bit accumulator has
    // nothing to shift, so it is handled separately.
    generate
        if (WIDTH == 1) begin : g_acc_one
            assign acc_next = fa_sum;
        end else begin : g_acc_multi
            assign acc_next = {fa_sum, acc[WIDTH-1:1]};
        end
    endgenerate

    assign busy = (state == BUSY);

    // Sequencer, operand shifters, bit counter and result registers.
    // done defaults low every cycle so it can only ever be a single pulse;
    // the result is copied from acc_next on the last bit so it appears in
    // the same edge as done rather than one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            cnt       <= '0;
            c_reg     <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        c_reg <= carry_in;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc   <= acc_next;
                    c_reg <= fa_carry;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        sum       <= acc_next;
                        carry_out <= fa_carry;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
// Self-checking bench for serial_adder: an 8-bit instance for the main
// scenarios and a 1-bit instance for the full-adder truth table.
// Expected results come from integer addition of the operands.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int errors;
    int checks;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start8),
        .a         (a8),
        .b         (b8),
        .carry_in  (cin8),
        .busy      (busy8),
        .done      (done8),
        .sum       (sum8),
        .carry_out (cout8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .a         (a1),
        .b         (b1),
        .carry_in  (cin1),
        .busy      (busy1),
        .done      (done1),
        .sum       (sum1),
        .carry_out (cout1)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: the full 9-bit result of a + b + carry_in
    function automatic logic [8:0] ref_add8(input logic [7:0] x, input logic [7:0] y,
                                            input logic c);
        int total;
        total = int'(x) + int'(y) + int'(c);
        return 9'(total);
    endfunction

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for exactly one edge (E0)
    task automatic launch8(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        a8     = ta;
        b8     = tb;
        cin8   = tc;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        #12;
        checks++;
        if ({busy8, done8, sum8, cout8} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_w8: got busy=%b done=%b sum=%h cout=%b, want all 0",
                     busy8, done8, sum8, cout8);
        end
        checks++;
        if ({busy1, done1, sum1, cout1} !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_w1: got busy=%b done=%b sum=%b cout=%b, want all 0",
                     busy1, done1, sum1, cout1);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        logic [7:0] va [3] = '{8'h5A, 8'hFF, 8'hFF};
        logic [7:0] vb [3] = '{8'h3C, 8'h01, 8'hFF};
        logic       vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [8:0] exp;
        logic [7:0] held_sum;
        logic       held_cout;
        for (int v = 0; v < 3; v++) begin
            exp       = ref_add8(va[v], vb[v], vc[v]);
            held_sum  = sum8;
            held_cout = cout8;
            launch8(va[v], vb[v], vc[v]);
            checks++;
            if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL directed_accept[%0d]: busy=%b done=%b, want busy=1 done=0",
                         v, busy8, done8);
            end
            for (int k = 1; k <= 8; k++) begin
                tick();
                if (k < 8) begin
                    checks++;
                    if (busy8 !== 1'b1 || done8 !== 1'b0 || sum8 !== held_sum || cout8 !== held_cout) begin
                        errors++;
                        $display("[TB] FAIL directed_busy[%0d] cycle %0d: busy=%b done=%b sum=%h cout=%b, want 1 0 %h %b",
                                 v, k, busy8, done8, sum8, cout8, held_sum, held_cout);
                    end
                end else begin
                    checks++;
                    if (busy8 !== 1'b0 || done8 !== 1'b1 || sum8 !== exp[7:0] || cout8 !== exp[8]) begin
                        errors++;
                        $display("[TB] FAIL directed_result[%0d]: busy=%b done=%b sum=%h cout=%b, want 0 1 %h %b",
                                 v, busy8, done8, sum8, cout8, exp[7:0], exp[8]);
                    end
                end
            end
            tick();
            checks++;
            if (done8 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL directed_pulse[%0d]: done=%b one cycle later, want 0", v, done8);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [8:0] exp;
        exp = ref_add8(8'h5A, 8'h3C, 1'b0);
        launch8(8'h5A, 8'h3C, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 3) begin
                a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
        end
        checks++;
        if (done8 !== 1'b1 || sum8 !== exp[7:0] || cout8 !== exp[8]) begin
            errors++;
            $display("[TB] FAIL ignore_start: done=%b sum=%h cout=%b, want 1 %h %b",
                     done8, sum8, cout8, exp[7:0], exp[8]);
        end
        tick();
        checks++;
        if (busy8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ignore_start_idle: busy=%b, want 0", busy8);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [8:0] exp;
        launch8(8'hC3, 8'h81, 1'b1);
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, sum8, cout8} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_op: busy=%b done=%b sum=%h cout=%b, want all 0",
                     busy8, done8, sum8, cout8);
        end
        repeat (2) tick();
        #2 rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (done8 !== 1'b0 || busy8 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_no_done cycle %0d: done=%b busy=%b, want 0 0",
                         k, done8, busy8);
            end
        end
        exp = ref_add8(8'h0F, 8'h0E, 1'b1);
        launch8(8'h0F, 8'h0E, 1'b1);
        repeat (8) tick();
        checks++;
        if (done8 !== 1'b1 || sum8 !== exp[7:0] || cout8 !== exp[8]) begin
            errors++;
            $display("[TB] FAIL reset_recover: done=%b sum=%h cout=%b, want 1 %h %b",
                     done8, sum8, cout8, exp[7:0], exp[8]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp1;
        logic [8:0] exp2;
        exp1 = ref_add8(8'h10, 8'h20, 1'b0);
        exp2 = ref_add8(8'h7F, 8'h01, 1'b0);
        launch8(8'h10, 8'h20, 1'b0);
        repeat (8) tick();
        checks++;
        if (done8 !== 1'b1 || sum8 !== exp1[7:0] || cout8 !== exp1[8]) begin
            errors++;
            $display("[TB] FAIL b2b_first: done=%b sum=%h cout=%b, want 1 %h %b",
                     done8, sum8, cout8, exp1[7:0], exp1[8]);
        end
        // start raised during the done cycle
        launch8(8'h7F, 8'h01, 1'b0);
        checks++;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_accept: busy=%b done=%b, want 1 0", busy8, done8);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (done8 !== (k == 8)) begin
                errors++;
                $display("[TB] FAIL b2b_done_timing cycle %0d: done=%b, want %b", k, done8, (k == 8));
            end
        end
        checks++;
        if (sum8 !== exp2[7:0] || cout8 !== exp2[8]) begin
            errors++;
            $display("[TB] FAIL b2b_second: sum=%h cout=%b, want %h %b",
                     sum8, cout8, exp2[7:0], exp2[8]);
        end
        tick();
    endtask

    task automatic test_random();
        logic [7:0] ta;
        logic [7:0] tb;
        logic       tc;
        logic [8:0] exp;
        for (int n = 0; n < 25; n++) begin
            ta  = 8'($urandom);
            tb  = 8'($urandom);
            tc  = 1'($urandom);
            exp = ref_add8(ta, tb, tc);
            launch8(ta, tb, tc);
            for (int k = 1; k <= 8; k++) begin
                // Spurious requests while busy must be ignored
                if ($urandom_range(0, 2) == 0) begin
                    start8 = 1'b1;
                    a8     = 8'($urandom);
                    b8     = 8'($urandom);
                    cin8   = 1'($urandom);
                end else begin
                    start8 = 1'b0;
                end
                tick();
            end
            start8 = 1'b0;
            checks++;
            if (done8 !== 1'b1 || sum8 !== exp[7:0] || cout8 !== exp[8]) begin
                errors++;
                $display("[TB] FAIL random[%0d] %h+%h+%b: done=%b sum=%h cout=%b, want 1 %h %b",
                         n, ta, tb, tc, done8, sum8, cout8, exp[7:0], exp[8]);
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        tick();
    endtask

    task automatic test_width1();
        int tot;
        for (int i = 0; i < 8; i++) begin
            a1   = 1'((i >> 2) & 1);
            b1   = 1'((i >> 1) & 1);
            cin1 = 1'(i & 1);
            tot  = ((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1);
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            checks++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL w1_accept[%0d]: busy=%b done=%b, want 1 0", i, busy1, done1);
            end
            tick();
            checks++;
            if (done1 !== 1'b1 || busy1 !== 1'b0 || sum1 !== 1'(tot & 1) || cout1 !== 1'(tot >> 1)) begin
                errors++;
                $display("[TB] FAIL w1_result[%0d]: done=%b busy=%b sum=%b cout=%b, want 1 0 %0d %0d",
                         i, done1, busy1, sum1, cout1, tot & 1, tot >> 1);
            end
        end
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        $display("[TB] serial_adder bench starting");
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        test_width1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
